// File: rtl/core_sequencer_pkg.sv
// Shared opcode package: instruction/register types, opcode masks, the
// sequencer state encoding and the branch-class decode helper.
package core_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [XLEN-1:0]   instruction_t;
  typedef logic [REG_AW-1:0] register_t;

  // casez masks; '?' bits are don't-care
  localparam instruction_t M_JAL   = 32'b?????????????????????????1101111;
  localparam instruction_t M_JALR  = 32'b?????????????????000?????1100111;
  localparam instruction_t M_BXX   = 32'b?????????????????????????1100011;
  localparam instruction_t M_OPIMM = 32'b?????????????????????????0010011;
  localparam instruction_t M_LOAD  = 32'b?????????????????????????0000011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    FWAIT  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    RETIRE = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  // True for JAL, JALR and conditional branches
  function automatic logic is_branch_op(input instruction_t instr);
    logic w_match;
    w_match = 1'b0;
    casez (instr)
      M_JAL, M_JALR, M_BXX: w_match = 1'b1;
      default:              w_match = 1'b0;
    endcase
    return w_match;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Instruction sequencer: fetches one instruction at a time from imem, decodes
// its branch class, launches execution and pulses step once per retirement.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_in               current PC from the branch unit
//   imem_req/addr       fetch request and address (address follows pc_in)
//   imem_gnt/rvalid     fetch accepted / fetch data valid
//   imem_rdata          fetched instruction
//   instr_out           latched instruction
//   branch_en           instruction is JAL/JALR/Bxx (DECODE through RETIRE)
//   step                one-cycle PC-advance pulse in RETIRE
//   exec_start          one-cycle start pulse in DECODE
//   exec_done           execute unit completion (honoured only in EXEC)
//   halt_req            stop at the next instruction boundary
//   halted              sequencer is stopped
//   fetch_err           sticky fetch timeout flag
//
// Build option: SEQ_FETCH_TIMEOUT_EN adds a fetch watchdog; without it
// fetch_err is tied low and FWAIT waits indefinitely.
module core_sequencer
  import core_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output instruction_t instr_out,
  output logic         branch_en,
  output logic         step,
  output logic         exec_start,
  input  logic         exec_done,
  input  logic         halt_req,
  output logic         halted,
  output logic         fetch_err
);

  seq_state_t   r_state;
  logic         r_imem_req;
  instruction_t r_instr;
  logic         r_branch_en;
  logic         r_step;
  logic         r_exec_start;
  logic         r_halted;

  logic         w_timeout;
  logic         w_locked;

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int unsigned WDOG_W     = 4;
  localparam int unsigned WDOG_LIMIT = 15;

  logic [WDOG_W-1:0] r_wdog;
  logic              r_fetch_err;
  logic              w_fetch_phase;
  logic              w_state_exit;

  assign w_fetch_phase = (r_state == FETCH) || (r_state == FWAIT);
  assign w_state_exit  = ((r_state == FETCH) && r_imem_req && imem_gnt) ||
                         ((r_state == FWAIT) && (imem_rvalid || w_timeout));
  // Fires on the 15th FWAIT cycle without data; arriving data wins
  assign w_timeout = (r_state == FWAIT) && !imem_rvalid &&
                     (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
  assign w_locked  = r_fetch_err;
  assign fetch_err = r_fetch_err;

  // Watchdog counter: counts cycles in the current fetch state
  always_ff @(posedge clk) begin
    if (rst || !w_fetch_phase || w_state_exit) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_err <= 1'b0;
    end else if (w_timeout) begin
      r_fetch_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_locked  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Sequencer FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_imem_req   <= 1'b0;
      r_instr      <= '0;
      r_branch_en  <= 1'b0;
      r_step       <= 1'b0;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_step       <= 1'b0;
      r_exec_start <= 1'b0;
      case (r_state)
        // First FETCH cycle after reset has no request out, so gnt is ignored
        FETCH: begin
          if (r_imem_req && imem_gnt) begin
            r_state    <= FWAIT;
            r_imem_req <= 1'b0;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        // branch_en is decoded from the same word being latched into instr_out
        FWAIT: begin
          if (imem_rvalid) begin
            r_instr      <= imem_rdata;
            r_branch_en  <= is_branch_op(imem_rdata);
            r_exec_start <= 1'b1;
            r_state      <= DECODE;
          end else if (w_timeout) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end
        end
        DECODE: begin
          r_state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            r_step  <= 1'b1;
            r_state <= RETIRE;
          end
        end
        RETIRE: begin
          r_branch_en <= 1'b0;
          if (halt_req) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end
        end
        HALT: begin
          if (!halt_req && !w_locked) begin
            r_halted   <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_halted   <= 1'b0;
          r_state    <= FETCH;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  // Fetch address is a direct feed-through so it tracks the PC the branch
  // unit updates at the end of RETIRE
  assign imem_addr  = pc_in;
  assign instr_out  = r_instr;
  assign branch_en  = r_branch_en;
  assign step       = r_step;
  assign exec_start = r_exec_start;
  assign halted     = r_halted;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam logic [31:0] I_ADDI  = 32'h00100093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JAL   = 32'h008000ef;
  localparam logic [31:0] I_JALR  = 32'h000080e7;
  localparam logic [31:0] I_JALRX = 32'h000090e7;
  localparam logic [31:0] I_LW    = 32'h0000a103;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  instruction_t instr_out;
  logic         branch_en;
  logic         step;
  logic         exec_start;
  logic         exec_done;
  logic         halt_req;
  logic         halted;
  logic         fetch_err;

  int vectors     = 0;
  int miscompares = 0;
  int overlap     = 0;

  core_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .branch_en  (branch_en),
    .step       (step),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .halt_req   (halt_req),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (step && exec_start) overlap++;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    exec_done   = 1'b0;
    halt_req    = 1'b0;
  endtask

  // Leaves the DUT in cycle 1: FETCH with the request out
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_in = 32'h0000_0040;
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", instr_out); end
    vectors++; if ({branch_en, step, exec_start, halted, fetch_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000", {branch_en, step, exec_start, halted, fetch_err}); end
    rst = 1'b0;
    tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_first_req: got %b expected 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0000_0040) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000040", imem_addr); end
  endtask

  task automatic test_latency();
    apply_reset();
    imem_gnt = 1'b1;                                   // cycle 1
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL lat_fwait_req: got %b expected 0", imem_req); end
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I_ADDI;  // cycle 2
    tick();
    imem_rvalid = 1'b0; imem_rdata = '0;               // cycle 3
    vectors++; if (exec_start !== 1'b1) begin miscompares++; $display("FAIL lat_exec_start: got %b expected 1", exec_start); end
    vectors++; if (instr_out !== I_ADDI) begin miscompares++; $display("FAIL lat_instr: got %h expected %h", instr_out, I_ADDI); end
    vectors++; if (step !== 1'b0) begin miscompares++; $display("FAIL lat_step_c3: got %b expected 0", step); end
    tick();
    exec_done = 1'b1;                                  // cycle 4
    vectors++; if (exec_start !== 1'b0) begin miscompares++; $display("FAIL lat_exec_start_c4: got %b expected 0", exec_start); end
    tick();
    exec_done = 1'b0;                                  // cycle 5
    vectors++; if (step !== 1'b1) begin miscompares++; $display("FAIL lat_step_c5: got %b expected 1", step); end
    vectors++; if (branch_en !== 1'b0) begin miscompares++; $display("FAIL lat_branch_en: got %b expected 0", branch_en); end
    tick();
    vectors++; if ({step, imem_req} !== 2'b01) begin miscompares++; $display("FAIL lat_refetch: got %b expected 01", {step, imem_req}); end
  endtask

  task automatic test_branch();
    int steps;
    apply_reset();
    steps = 0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I_BEQ;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if (branch_en !== 1'b1) begin miscompares++; $display("FAIL beq_decode: got %b expected 1", branch_en); end
    tick();
    exec_done = 1'b1;
    vectors++; if (branch_en !== 1'b1) begin miscompares++; $display("FAIL beq_exec: got %b expected 1", branch_en); end
    tick();
    exec_done = 1'b0;
    vectors++; if ({branch_en, step} !== 2'b11) begin miscompares++; $display("FAIL beq_retire: got %b expected 11", {branch_en, step}); end
    steps += int'(step);
    for (int i = 0; i < 4; i++) begin
      tick();
      steps += int'(step);
    end
    vectors++; if (branch_en !== 1'b0) begin miscompares++; $display("FAIL beq_clear: got %b expected 0", branch_en); end
    vectors++; if (steps !== 1) begin miscompares++; $display("FAIL beq_step_count: got %0d expected 1", steps); end
  endtask

  task automatic test_decode();
    logic [31:0] words [6];
    logic        exp   [6];
    words = '{I_ADDI, I_BEQ, I_JAL, I_JALR, I_JALRX, I_LW};
    exp   = '{1'b0,   1'b1,  1'b1,  1'b1,   1'b0,    1'b0};
    for (int k = 0; k < 6; k++) begin
      apply_reset();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = words[k];
      tick();
      imem_rvalid = 1'b0;
      vectors++; if (branch_en !== exp[k]) begin
        miscompares++; $display("FAIL decode_%0d: instr %h got %b expected %b", k, words[k], branch_en, exp[k]); end
    end
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    pc_in = 32'h0000_0100;
    for (int i = 0; i < 6; i++) begin
      vectors++; if ({imem_req, imem_addr, step} !== {1'b1, 32'h0000_0100, 1'b0}) begin
        miscompares++; $display("FAIL stall_%0d: got req=%b addr=%h step=%b expected 1/00000100/0", i, imem_req, imem_addr, step); end
      tick();
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_granted: got %b expected 0", imem_req); end
  endtask

  task automatic test_same_cycle_rvalid();
    apply_reset();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = I_BEQ;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick();
    vectors++; if ({exec_start, instr_out} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL early_rvalid: got start=%b instr=%h expected 0/00000000", exec_start, instr_out); end
    imem_rvalid = 1'b1; imem_rdata = I_ADDI;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if ({exec_start, instr_out} !== {1'b1, I_ADDI}) begin
      miscompares++; $display("FAIL fwait_rvalid: got start=%b instr=%h expected 1/%h", exec_start, instr_out, I_ADDI); end
  endtask

  task automatic test_exec_done_ignored();
    apply_reset();
    exec_done = 1'b1;                 // high from FETCH through DECODE
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I_ADDI;
    tick();
    imem_rvalid = 1'b0;               // DECODE, exec_done still high
    tick();
    exec_done = 1'b0;                 // EXEC
    vectors++; if (step !== 1'b0) begin miscompares++; $display("FAIL done_early_c4: got %b expected 0", step); end
    tick();
    vectors++; if (step !== 1'b0) begin miscompares++; $display("FAIL done_early_c5: got %b expected 0", step); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    vectors++; if (step !== 1'b1) begin miscompares++; $display("FAIL done_late_step: got %b expected 1", step); end
  endtask

  task automatic test_halt();
    apply_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I_ADDI;
    tick();
    imem_rvalid = 1'b0;
    tick();
    halt_req = 1'b1;                  // EXEC, done not yet
    tick();
    vectors++; if ({step, halted} !== 2'b00) begin miscompares++; $display("FAIL halt_exec: got %b expected 00", {step, halted}); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    vectors++; if ({step, halted} !== 2'b10) begin miscompares++; $display("FAIL halt_retire: got %b expected 10", {step, halted}); end
    tick();
    vectors++; if ({halted, imem_req, step, exec_start} !== 4'b1000) begin
      miscompares++; $display("FAIL halt_entered: got %b expected 1000", {halted, imem_req, step, exec_start}); end
    tick();
    tick();
    vectors++; if ({halted, imem_req} !== 2'b10) begin miscompares++; $display("FAIL halt_hold: got %b expected 10", {halted, imem_req}); end
    halt_req = 1'b0;
    tick();
    vectors++; if ({halted, imem_req} !== 2'b01) begin miscompares++; $display("FAIL halt_resume: got %b expected 01", {halted, imem_req}); end
  endtask

  task automatic test_rst_fwait();
    apply_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;                  // FWAIT, request outstanding
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if ({imem_req, instr_out} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL rstfw_reset: got req=%b instr=%h expected 0/00000000", imem_req, instr_out); end
    tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rstfw_fresh_req: got %b expected 1", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = I_BEQ;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if ({exec_start, branch_en, instr_out, imem_req} !== {2'b00, 32'h0, 1'b1}) begin
      miscompares++; $display("FAIL rstfw_late_rvalid: got start=%b br=%b instr=%h req=%b expected 0/0/00000000/1",
                              exec_start, branch_en, instr_out, imem_req); end
  endtask

  task automatic test_timeout();
    apply_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      vectors++; if ({fetch_err, halted} !== 2'b00) begin
        miscompares++; $display("FAIL wdog_fwait_%0d: got %b expected 00", k, {fetch_err, halted}); end
      tick();
    end
    vectors++; if ({fetch_err, halted, imem_req} !== 3'b110) begin
      miscompares++; $display("FAIL wdog_trip: got %b expected 110", {fetch_err, halted, imem_req}); end
    halt_req = 1'b1;
    tick();
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++; if ({fetch_err, halted, imem_req} !== 3'b110) begin
      miscompares++; $display("FAIL wdog_locked: got %b expected 110", {fetch_err, halted, imem_req}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if ({fetch_err, halted} !== 2'b00) begin
      miscompares++; $display("FAIL wdog_rst_clear: got %b expected 00", {fetch_err, halted}); end
`else
    for (int i = 0; i < 20; i++) tick();
    vectors++; if ({fetch_err, halted, exec_start, imem_req} !== 4'b0000) begin
      miscompares++; $display("FAIL nowdog_wait: got %b expected 0000", {fetch_err, halted, exec_start, imem_req}); end
    imem_rvalid = 1'b1; imem_rdata = I_ADDI;
    tick();
    imem_rvalid = 1'b0;
    vectors++; if ({exec_start, instr_out} !== {1'b1, I_ADDI}) begin
      miscompares++; $display("FAIL nowdog_late_data: got start=%b instr=%h expected 1/%h", exec_start, instr_out, I_ADDI); end
`endif
  endtask

  task automatic test_exclusive();
    vectors++; if (overlap !== 0) begin
      miscompares++; $display("FAIL step_start_overlap: got %0d cycles expected 0", overlap); end
  endtask

  initial begin
    rst   = 1'b1;
    pc_in = '0;
    idle_inputs();
    test_reset();
    test_latency();
    test_branch();
    test_decode();
    test_gnt_stall();
    test_same_cycle_rvalid();
    test_exec_done_ignored();
    test_halt();
    test_rst_fwait();
    test_timeout();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
